sync_pulse_decoder: RTL and testbench

SYNC_PULSE_DECODER -- requirements
Module: sync_pulse_decoder

---
 rtl/lighthouse_pkg.sv | 33 +++
 rtl/glitch_filter.sv | 51 +++++
 rtl/sync_pulse_decoder.sv | 81 ++++++++
 tb/tb_sync_pulse_decoder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lighthouse_pkg.sv
// rtl/lighthouse_pkg.sv - shared widths, thresholds, FSM encoding and code decoder
package lighthouse_pkg;

  localparam int WIDTH_BITS = 13;
  typedef logic [WIDTH_BITS-1:0] width_t;

  localparam width_t MIN_SYNC = width_t'(2865);
  localparam width_t MAX_SYNC = width_t'(7032);
  localparam width_t BASE     = width_t'(3125);
  localparam width_t STEP     = width_t'(521);
  localparam width_t CNT_MAX  = '1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MEAS = 2'd1;
  localparam state_t ST_LONG = 2'd2;

  // T_k = MIN_SYNC + k*STEP
  localparam width_t T_TABLE [1:7] = '{
    width_t'(3386), width_t'(3907), width_t'(4428), width_t'(4949),
    width_t'(5470), width_t'(5991), width_t'(6512)
  };

  function automatic logic [2:0] decode_code(input width_t w);
    logic [2:0] c;
    c = '0;
    for (int k = 1; k <= 7; k++) begin
      if (w >= T_TABLE[k]) c = c + 3'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// rtl/glitch_filter.sv - 2-flop synchronizer plus consecutive-cycle glitch filter
module glitch_filter #(
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic level
);

  localparam int CW = $clog2(GLITCH_CYCLES + 3);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] cnt;

  // Until armed, the input must be seen low long enough so a pulse in flight at reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= sig;
      s2 <= s1;
      if (!armed) begin
        if (s2) begin
          cnt <= '0;
        end else if (cnt == CW'(GLITCH_CYCLES + 1)) begin
          armed <= 1'b1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (s2 != level) begin
        if (cnt == CW'(GLITCH_CYCLES - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sync_pulse_decoder.sv
// rtl/sync_pulse_decoder.sv - measures filtered high periods and classifies them as sweep, sync or overlong
module sync_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter int GLITCH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig,
  output logic                  sync_start,
  output logic                  sync_valid,
  output logic [2:0]            sync_code,
  output logic [WIDTH_BITS-1:0] sync_width,
  output logic                  sweep_valid,
  output logic                  err_long,
  output logic                  level
);

  state_t state;
  width_t cnt;
  logic   level_d;
  logic   rise;
  logic   fall;

  glitch_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filter (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig),
    .level (level)
  );

  assign rise       = level & ~level_d;
  assign fall       = ~level & level_d;
  assign sync_start = (state == ST_MEAS) && (cnt == MIN_SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      level_d     <= 1'b0;
      sync_valid  <= 1'b0;
      sweep_valid <= 1'b0;
      err_long    <= 1'b0;
      sync_code   <= '0;
      sync_width  <= '0;
    end else begin
      level_d     <= level;
      sync_valid  <= 1'b0;
      sweep_valid <= 1'b0;
      err_long    <= 1'b0;

      if (rise) begin
        cnt <= width_t'(1);
      end else if (level) begin
        if (cnt != CNT_MAX) cnt <= cnt + width_t'(1);
      end else begin
        cnt <= '0;
      end

      case (state)
        ST_IDLE: if (rise) state <= ST_MEAS;
        ST_MEAS: begin
          if (fall) state <= ST_IDLE;
          else if (cnt == MAX_SYNC + width_t'(1)) state <= ST_LONG;
        end
        ST_LONG: if (fall) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Classify on the count itself: a fall can coincide with the MEAS->LONG step.
      if (fall && state != ST_IDLE) begin
        sweep_valid <= (cnt < MIN_SYNC);
        sync_valid  <= (cnt >= MIN_SYNC) && (cnt <= MAX_SYNC);
        err_long    <= (cnt > MAX_SYNC);
        sync_width  <= cnt;
        sync_code   <= decode_code(cnt);
      end
    end
  end

endmodule

// File: tb/tb_sync_pulse_decoder.sv
// tb/tb_sync_pulse_decoder.sv - scoreboard bench for sync_pulse_decoder
module tb_sync_pulse_decoder;

  localparam int K_SWEEP = 0;
  localparam int K_SYNC  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int n;
    int gap;
    int kind;
    int code;
    int width;
    int delta;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig = 1'b0;
  logic        sync_start;
  logic        sync_valid;
  logic [2:0]  sync_code;
  logic [12:0] sync_width;
  logic        sweep_valid;
  logic        err_long;
  logic        level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  vec_t exp_q[$];

  vec_t vecs [10] = '{
    '{3125, 30, K_SYNC,  0, 3125,  261},
    '{5730, 30, K_SYNC,  5, 5730, 2866},
    '{2864, 30, K_SWEEP, 0, 2864,   -1},
    '{2865, 30, K_SYNC,  0, 2865,    1},
    '{7032, 30, K_SYNC,  7, 7032, 4168},
    '{7033, 30, K_ERR,   7, 7033, 4169},
    '{9000, 30, K_ERR,   7, 8191, 6136},
    '{3386,  5, K_SYNC,  1, 3386,  522},
    '{3385,  5, K_SYNC,  0, 3385,  521},
    '{ 100, 30, K_SWEEP, 0,  100,   -1}
  };

  sync_pulse_decoder #(.GLITCH_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sig         (sig),
    .sync_start  (sync_start),
    .sync_valid  (sync_valid),
    .sync_code   (sync_code),
    .sync_width  (sync_width),
    .sweep_valid (sweep_valid),
    .err_long    (err_long),
    .level       (level)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Monitor: pops one expectation per classification pulse.
  always @(negedge clk) begin
    vec_t e;
    int   got_kind;
    cyc++;
    if (rst) begin
      start_cnt = 0;
    end else begin
      if (sync_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (sync_valid || sweep_valid || err_long) begin
        got_kind = sweep_valid ? K_SWEEP : (sync_valid ? K_SYNC : K_ERR);
        check("onehot", $countones({sync_valid, sweep_valid, err_long}), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_class", got_kind, 99);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("kind_%0d", e.n), got_kind, e.kind);
          check($sformatf("code_%0d", e.n), sync_code, e.code);
          check($sformatf("width_%0d", e.n), sync_width, e.width);
          if (e.delta < 0) begin
            check($sformatf("no_start_%0d", e.n), start_cnt, 0);
          end else begin
            check($sformatf("start_cnt_%0d", e.n), start_cnt, 1);
            check($sformatf("start_delta_%0d", e.n), cyc - start_cyc, e.delta);
          end
        end
        start_cnt = 0;
      end
    end
  end

  task automatic pulse(input int n, input int gap);
    @(posedge clk); #1 sig = 1'b1;
    repeat (n) @(posedge clk);
    #1 sig = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic lvl_seen;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_pulses", {sync_start, sync_valid, sweep_valid, err_long}, 0);
    check("rst_code", sync_code, 0);
    check("rst_width", sync_width, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      pulse(vecs[i].n, vecs[i].gap);
      if (vecs[i].gap >= 30) drain();
    end
    drain();

    lvl_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1 sig = (i < 3);
      @(negedge clk); lvl_seen |= level;
    end
    check("glitch_level", lvl_seen, 0);

    // Reset mid-pulse: the interrupted period and its remainder must be dropped.
    @(posedge clk); #1 sig = 1'b1;
    repeat (4000) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    repeat (990) @(posedge clk);
    #1 sig = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("post_rst_width", sync_width, 0);
    check("post_rst_level", level, 0);

    exp_q.push_back('{3125, 30, K_SYNC, 0, 3125, 261});
    pulse(3125, 30);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
